// File: rtl/seg_i2c_target_if.sv
// I2C pin bundle between the display driver's master and the segment target.
// The target samples scl_i/sda_in and answers through an open-drain sda_out/sda_out_en pair.
interface seg_i2c_target_if;
    logic scl_i;
    logic sda_in;
    logic sda_out;
    logic sda_out_en;

    modport master (output scl_i, output sda_in, input sda_out, input sda_out_en);
    modport slave  (input scl_i, input sda_in, output sda_out, output sda_out_en);
endinterface

// File: rtl/seg_i2c_target.sv
// Write-only I2C target that commits four digit bytes to digits_o on STOP.
// Optional feature macro: SEG_TGT_READBACK_EN adds an R/W=1 read path returning d0..d3.
module seg_i2c_target #(
    parameter logic [6:0]  TGT_ADDR    = 7'h38,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    seg_i2c_target_if.slave   bus,
    output logic [31:0]       digits_o,
    output logic              frame_valid_o,
    output logic              frame_err_o,
    output logic              busy_o
);
    localparam int unsigned BIT_CNT_W = 4;
    localparam int unsigned CNT_W     = 3;
    localparam logic [CNT_W-1:0]     CNT_FULL = CNT_W'(4);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(7);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_DATA     = 3'd3,
        ST_DATA_ACK = 3'd4,
        ST_IGNORE   = 3'd5
`ifdef SEG_TGT_READBACK_EN
        ,
        ST_READ     = 3'd6,
        ST_READ_ACK = 3'd7
`endif
    } state_t;

    // Input synchronizers plus one delayed copy for edge detection; idle bus level is high.
    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_d;
    logic                   r_sda_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], bus.scl_i};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], bus.sda_in};
            r_scl_d    <= r_scl_sync[SYNC_STAGES-1];
            r_sda_d    <= r_sda_sync[SYNC_STAGES-1];
        end
    end

    logic w_scl;
    logic w_sda;
    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise = w_scl & ~r_scl_d;
    assign w_scl_fall = ~w_scl & r_scl_d;
    assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

    state_t               r_state,   w_state_nxt;
    logic [BIT_CNT_W-1:0] r_bit_cnt, w_bit_cnt_nxt;
    logic [7:0]           r_shift,   w_shift_nxt;
    logic [CNT_W-1:0]     r_cnt,     w_cnt_nxt;
    logic                 r_ovf,     w_ovf_nxt;
    logic                 r_phase,   w_phase_nxt;
    logic                 r_sda_oe,  w_sda_oe_nxt;
    logic [31:0]          r_shadow,  w_shadow_nxt;
    logic [31:0]          r_digits,  w_digits_nxt;
    logic                 r_fv,      w_fv_nxt;
    logic                 r_fe,      w_fe_nxt;
    logic                 r_busy,    w_busy_nxt;
`ifdef SEG_TGT_READBACK_EN
    logic                 r_rd,      w_rd_nxt;
    logic [7:0]           r_tx,      w_tx_nxt;
    logic [1:0]           r_idx,     w_idx_nxt;
    logic                 r_mack,    w_mack_nxt;
    logic [1:0]           w_idx_inc;
    assign w_idx_inc = r_idx + 2'd1;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_phase   <= 1'b0;
            r_sda_oe  <= 1'b0;
            r_shadow  <= '0;
            r_digits  <= '0;
            r_fv      <= 1'b0;
            r_fe      <= 1'b0;
            r_busy    <= 1'b0;
`ifdef SEG_TGT_READBACK_EN
            r_rd      <= 1'b0;
            r_tx      <= '0;
            r_idx     <= '0;
            r_mack    <= 1'b1;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_cnt     <= w_cnt_nxt;
            r_ovf     <= w_ovf_nxt;
            r_phase   <= w_phase_nxt;
            r_sda_oe  <= w_sda_oe_nxt;
            r_shadow  <= w_shadow_nxt;
            r_digits  <= w_digits_nxt;
            r_fv      <= w_fv_nxt;
            r_fe      <= w_fe_nxt;
            r_busy    <= w_busy_nxt;
`ifdef SEG_TGT_READBACK_EN
            r_rd      <= w_rd_nxt;
            r_tx      <= w_tx_nxt;
            r_idx     <= w_idx_nxt;
            r_mack    <= w_mack_nxt;
`endif
        end
    end

    // Bus conditions first (START/STOP win over bit sampling), then per-state SCL edge handling.
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_cnt_nxt     = r_cnt;
        w_ovf_nxt     = r_ovf;
        w_phase_nxt   = r_phase;
        w_sda_oe_nxt  = r_sda_oe;
        w_shadow_nxt  = r_shadow;
        w_digits_nxt  = r_digits;
        w_fv_nxt      = 1'b0;
        w_fe_nxt      = 1'b0;
        w_busy_nxt    = 1'b0;
`ifdef SEG_TGT_READBACK_EN
        w_rd_nxt      = r_rd;
        w_tx_nxt      = r_tx;
        w_idx_nxt     = r_idx;
        w_mack_nxt    = r_mack;
`endif

        if (w_start) begin
            w_state_nxt   = ST_ADDR;
            w_bit_cnt_nxt = '0;
            w_cnt_nxt     = '0;
            w_ovf_nxt     = 1'b0;
            w_phase_nxt   = 1'b0;
            w_sda_oe_nxt  = 1'b0;
`ifdef SEG_TGT_READBACK_EN
            w_rd_nxt      = 1'b0;
`endif
        end else if (w_stop) begin
            if (r_state == ST_ADDR_ACK || r_state == ST_DATA || r_state == ST_DATA_ACK) begin
                if (r_cnt == CNT_FULL && !r_ovf) begin
                    w_digits_nxt = r_shadow;
                    w_fv_nxt     = 1'b1;
                end else begin
                    w_fe_nxt     = 1'b1;
                end
            end
            w_state_nxt   = ST_IDLE;
            w_bit_cnt_nxt = '0;
            w_phase_nxt   = 1'b0;
            w_sda_oe_nxt  = 1'b0;
        end else begin
            case (r_state)
                ST_ADDR: begin
                    if (w_scl_rise) begin
                        w_shift_nxt   = {r_shift[6:0], w_sda};
                        w_bit_cnt_nxt = r_bit_cnt + BIT_CNT_W'(1);
                        if (r_bit_cnt == LAST_BIT) begin
                            w_bit_cnt_nxt = '0;
                            w_phase_nxt   = 1'b0;
                            if (r_shift[6:0] != TGT_ADDR) begin
                                w_state_nxt = ST_IGNORE;
                            end else if (!w_sda) begin
                                w_state_nxt = ST_ADDR_ACK;
`ifdef SEG_TGT_READBACK_EN
                            end else begin
                                w_state_nxt = ST_ADDR_ACK;
                                w_rd_nxt    = 1'b1;
                            end
`else
                            end else begin
                                w_state_nxt = ST_IGNORE;
                            end
`endif
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    // First SCL fall pulls SDA low, second one releases it and moves on.
                    if (w_scl_fall) begin
                        if (!r_phase) begin
                            w_phase_nxt  = 1'b1;
                            w_sda_oe_nxt = 1'b1;
                        end else begin
                            w_phase_nxt   = 1'b0;
                            w_sda_oe_nxt  = 1'b0;
                            w_cnt_nxt     = '0;
                            w_ovf_nxt     = 1'b0;
                            w_bit_cnt_nxt = '0;
                            w_state_nxt   = ST_DATA;
`ifdef SEG_TGT_READBACK_EN
                            if (r_rd) begin
                                w_state_nxt  = ST_READ;
                                w_idx_nxt    = '0;
                                w_tx_nxt     = r_digits[7:0];
                                w_sda_oe_nxt = ~r_digits[7];
                            end
`endif
                        end
                    end
                end
                ST_DATA: begin
                    if (w_scl_rise) begin
                        w_shift_nxt   = {r_shift[6:0], w_sda};
                        w_bit_cnt_nxt = r_bit_cnt + BIT_CNT_W'(1);
                        if (r_bit_cnt == LAST_BIT) begin
                            w_bit_cnt_nxt = '0;
                            w_phase_nxt   = 1'b0;
                            w_state_nxt   = ST_DATA_ACK;
                        end
                    end
                end
                ST_DATA_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_phase) begin
                            w_phase_nxt = 1'b1;
                            if (r_cnt < CNT_FULL) begin
                                w_sda_oe_nxt = 1'b1;
                                w_shadow_nxt[{r_cnt[1:0], 3'b000} +: 8] = r_shift;
                                w_cnt_nxt    = r_cnt + CNT_W'(1);
                            end else begin
                                w_ovf_nxt    = 1'b1;
                            end
                        end else begin
                            w_phase_nxt  = 1'b0;
                            w_sda_oe_nxt = 1'b0;
                            w_state_nxt  = ST_DATA;
                        end
                    end
                end
`ifdef SEG_TGT_READBACK_EN
                ST_READ: begin
                    if (w_scl_rise) begin
                        w_bit_cnt_nxt = r_bit_cnt + BIT_CNT_W'(1);
                    end else if (w_scl_fall) begin
                        if (r_bit_cnt == BIT_CNT_W'(8)) begin
                            w_bit_cnt_nxt = '0;
                            w_sda_oe_nxt  = 1'b0;
                            w_state_nxt   = ST_READ_ACK;
                        end else begin
                            w_tx_nxt      = {r_tx[6:0], 1'b0};
                            w_sda_oe_nxt  = ~r_tx[6];
                        end
                    end
                end
                ST_READ_ACK: begin
                    if (w_scl_rise) begin
                        w_mack_nxt = w_sda;
                    end else if (w_scl_fall) begin
                        if (!r_mack) begin
                            w_idx_nxt    = w_idx_inc;
                            w_tx_nxt     = r_digits[{w_idx_inc, 3'b000} +: 8];
                            w_sda_oe_nxt = ~r_digits[{w_idx_inc, 3'b111}];
                            w_state_nxt  = ST_READ;
                        end else begin
                            w_state_nxt  = ST_IGNORE;
                        end
                    end
                end
`endif
                ST_IDLE, ST_IGNORE: begin
                    w_sda_oe_nxt = 1'b0;
                end
                default: begin
                    w_state_nxt  = ST_IDLE;
                    w_sda_oe_nxt = 1'b0;
                end
            endcase
        end

        case (w_state_nxt)
            ST_ADDR_ACK, ST_DATA, ST_DATA_ACK: w_busy_nxt = 1'b1;
`ifdef SEG_TGT_READBACK_EN
            ST_READ, ST_READ_ACK:              w_busy_nxt = 1'b1;
`endif
            default:                           w_busy_nxt = 1'b0;
        endcase
    end

    assign bus.sda_out    = 1'b0;
    assign bus.sda_out_en = r_sda_oe;
    assign digits_o       = r_digits;
    assign frame_valid_o  = r_fv;
    assign frame_err_o    = r_fe;
    assign busy_o         = r_busy;
endmodule

// File: doc/seg_i2c_target.md
# seg_i2c_target

I2C target (responder) for the 7-segment display link: it sits on the far end of the open-drain SDA/SCL pair driven by the display driver's I2C master. It decodes write frames addressed to it, ACKs each byte, and on STOP commits four digit bytes to a 32-bit register for the segment decoder and for bench loopback. It never drives SCL and does no clock stretching.

## Interface
Parameters:
- TGT_ADDR, 7'h38, 7-bit target address matched on the first byte after START.
- SYNC_STAGES, 2, flip-flop stages on scl_i and sda_in (legal range 2..4).

Ports:
- clk_i  input  1  system clock; must be at least 16x the SCL frequency.
- rst_i  input  1  asynchronous, active-high reset.
- scl_i  input  1  bus SCL (asynchronous).
- sda_in  input  1  bus SDA (asynchronous).
- sda_out  output  1  SDA drive value; constant 0 (open-drain).
- sda_out_en  output  1  1 = pull SDA low (ACK or read data 0).
- digits_o  output  32  committed digits {d3,d2,d1,d0}; d0 is the first data byte received.
- frame_valid_o  output  1  one-cycle pulse when digits_o updates.
- frame_err_o  output  1  one-cycle pulse on STOP after a short or overlong frame.
- busy_o  output  1  1 from an address-matched START until STOP, repeated START, or abort.

## Operation
- Synchronize scl_i and sda_in through SYNC_STAGES flops. Keep one extra registered copy for edge detection.
- START: synchronized SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both are detected in any state and take priority over bit sampling.
- Sample bits MSB first on the SCL rising edge. Shift sda_out_en only on the SCL falling edge.
- Data bytes go into a 4-byte shadow buffer with a 3-bit byte counter, cnt.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits. If addr == TGT_ADDR and R/W = 0, go to ADDR_ACK. If R/W = 1 (no readback), go to IGNORE. If the address does not match, go to IGNORE.
  - ADDR_ACK: assert sda_out_en from SCL falling edge 8 to SCL falling edge 9. Clear cnt. Go to DATA.
  - DATA: shift 8 bits, then go to DATA_ACK.
  - DATA_ACK: if cnt < 4, ACK, store the byte at shadow[cnt], cnt++. If cnt is already 4, NACK (sda_out_en stays 0) and set the overflow flag. Return to DATA.
  - IGNORE: never drive; wait for START or STOP.
- On STOP:
  - cnt == 4 and no overflow: copy shadow to digits_o and pulse frame_valid_o.
  - Any other matched frame (cnt 0..3 or overflow): pulse frame_err_o; digits_o holds.
  - Go to IDLE.
- Repeated START: discard the shadow buffer and cnt, and go to ADDR. No pulse is issued.
- busy_o = 1 in ADDR_ACK, DATA, DATA_ACK (and the read states).

## Timing
- Reset values: sda_out = 0, sda_out_en = 0, digits_o = 32'h0, frame_valid_o = 0, frame_err_o = 0, busy_o = 0. State is IDLE, cnt = 0, and the overflow flag is clear.
- Input latency: SYNC_STAGES + 1 clk_i cycles from a pin edge to detection.
- STOP to digits_o/frame_valid_o: SYNC_STAGES + 2 cycles after the SDA rising edge at the pin. Pulses are exactly 1 cycle wide.
- sda_out_en changes SYNC_STAGES + 2 cycles after the SCL falling edge at the pin, which is well inside SCL low.
- If rst_i is asserted mid-frame, SDA is released immediately (asynchronously), no pulse is issued, and digits_o is cleared.
- STOP arriving mid-byte aborts the frame with frame_err_o (matched frames only).
- A START in IDLE and a STOP on consecutive edges form an empty frame: no pulse, because busy_o was never asserted.

## Configuration
- SEG_TGT_READBACK_EN defined:
  - An address match with R/W = 1 is ACKed and the block enters READ.
  - READ drives digits_o bytes d0..d3 MSB first. Each bit is driven on the SCL falling edge (sda_out_en = ~bit).
  - After each byte, SDA is released for the master's ACK (READ_ACK). A master ACK continues with the next byte, wrapping d3 to d0. A master NACK goes to IGNORE.
  - No frame pulses are issued for reads.
- SEG_TGT_READBACK_EN undefined: R/W = 1 frames go to IGNORE and are NACKed, and the READ/READ_ACK logic is not present.

## Test plan
- Write 0x70, bytes 3F 06 5B 4F, STOP: 5 ACKs seen, digits_o = 32'h4F5B063F, and one frame_valid_o pulse.
- Write to address 0x39 with 4 bytes: no ACK at any bit 9, busy_o stays 0, no pulses, and digits_o unchanged.
- Write 0x70 with 3F 06, STOP: frame_err_o pulses and digits_o holds its prior value. Write 0x70 with 5 bytes: the 5th byte is NACKed and frame_err_o pulses on STOP.
- Write 0x70 with 11 22, repeated START, then 0x70 with AA BB CC DD, STOP: digits_o = 32'hDDCCBBAA, and exactly one frame_valid_o pulse.
- Assert rst_i during the ACK of byte 2: sda_out_en drops in the same cycle, digits_o = 0, and the next full frame commits normally.
- With SEG_TGT_READBACK_EN: after committing 32'h4F5B063F, read 0x71 for 4 bytes (master ACKs bytes 1..3, NACKs byte 4): the bench reads 3F 06 5B 4F.
